// File: rtl/adam_rst_seq.sv
// Power-on / software reset sequencer: holds all domains in reset, then releases them one by one in index order.
// Optional macro ADAM_RST_SEQ_SW_REQ_EN enables the req/ack software re-sequence handshake.
module adam_rst_seq #(
  parameter int NO_DOMAINS = 4,
  parameter int HOLD       = 8,
  parameter int DELAY      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  ack,
  output logic                  busy,
  output logic [NO_DOMAINS-1:0] dom_rst
);

  // state   | meaning
  // ASSERT  | all domains held in reset, counting HOLD cycles
  // RELEASE | releasing domains in index order, DELAY cycles apart
  // RUN     | all domains released, sequencer idle

  localparam int CNT_MAX = (HOLD > DELAY) ? HOLD : DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NO_DOMAINS) + 1;

  localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD - 1);
  localparam logic [CW-1:0] DELAY_TC = CW'(DELAY - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NO_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NO_DOMAINS-1:0]   dom_q, dom_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    accept;

`ifdef ADAM_RST_SEQ_SW_REQ_EN
  assign accept = req & ack_q;
`else
  logic req_unused;
  assign req_unused = req;
  assign accept     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;

    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_TC) begin
          dom_d[0] = 1'b0;
          cnt_d    = '0;
          if (NO_DOMAINS == 1) begin
            state_d = ST_RUN;
          end else begin
            idx_d   = IW'(1);
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RELEASE: begin
        if (cnt_q == DELAY_TC) begin
          for (int i = 0; i < NO_DOMAINS; i++) begin
            if (idx_q == IW'(i)) dom_d[i] = 1'b0;
          end
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        if (accept) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '1;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        idx_d   = '0;
        dom_d   = '1;
      end
    endcase

    // Handshake outputs are derived from the next state so they register alongside it.
`ifdef ADAM_RST_SEQ_SW_REQ_EN
    ack_d  = (state_d == ST_RUN);
`else
    ack_d  = 1'b0;
`endif
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign dom_rst = dom_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Bench for adam_rst_seq: directed vector table, hand-written corner sequences and a random phase checked against a timeline model.
module tb_adam_rst_seq;

  localparam int N     = 4;
  localparam int HOLD  = 8;
  localparam int DELAY = 4;
  localparam int LAST  = HOLD + (N - 1) * DELAY;
`ifdef ADAM_RST_SEQ_SW_REQ_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         req;
  logic         ack;
  logic         busy;
  logic [N-1:0] dom_rst;

  int checks   = 0;
  int failures = 0;
  int m_s      = 0;  // edges since the current sequence started

  adam_rst_seq #(.NO_DOMAINS(N), .HOLD(HOLD), .DELAY(DELAY)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .busy    (busy),
    .dom_rst (dom_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         req;
    logic [N-1:0] dom;
    logic         ack;
    logic         busy;
  } vec_t;

  vec_t vecs[32];

  function automatic logic [N-1:0] m_dom(input int s);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (s < HOLD + i * DELAY);
    return r;
  endfunction

  function automatic logic m_ack(input int s);
    return SW && (s >= LAST);
  endfunction

  function automatic logic m_busy(input int s);
    return (s < LAST);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic q);
    logic pre_ack;
    rst = r;
    req = q;
    @(posedge clk);
    pre_ack = m_ack(m_s);
    if (r)                 m_s = 0;
    else if (q && pre_ack) m_s = 0;
    else if (m_s < LAST + 4) m_s = m_s + 1;
    #1;
    chk("model_dom",  32'(dom_rst), 32'(m_dom(m_s)));
    chk("model_ack",  32'(ack),     32'(m_ack(m_s)));
    chk("model_busy", 32'(busy),    32'(m_busy(m_s)));
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;

    // Vector table: power-up sequence, then one software request from RUN at row 22.
    vecs[0] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
    for (int k = 1; k < 22; k++) begin
      vecs[k].rst  = 1'b0;
      vecs[k].req  = 1'b0;
      vecs[k].dom  = (k < 8) ? 4'hF : (k < 12) ? 4'hE : (k < 16) ? 4'hC : (k < 20) ? 4'h8 : 4'h0;
      vecs[k].ack  = SW && (k >= 20);
      vecs[k].busy = (k < 20);
    end
    for (int k = 22; k < 32; k++) begin
      vecs[k].rst = 1'b0;
      vecs[k].req = (k == 22);
      if (SW) begin
        vecs[k].dom  = ((k - 22) < 8) ? 4'hF : 4'hE;
        vecs[k].ack  = 1'b0;
        vecs[k].busy = 1'b1;
      end else begin
        vecs[k].dom  = 4'h0;
        vecs[k].ack  = 1'b0;
        vecs[k].busy = 1'b0;
      end
    end

    for (int i = 0; i < 32; i++) begin
      step(vecs[i].rst, vecs[i].req);
      chk($sformatf("vec%0d_dom", i),  32'(dom_rst), 32'(vecs[i].dom));
      chk($sformatf("vec%0d_ack", i),  32'(ack),     32'(vecs[i].ack));
      chk($sformatf("vec%0d_busy", i), 32'(busy),    32'(vecs[i].busy));
    end

    // req held high from mid-RELEASE: ignored until RUN, accepted on the first edge with ack=1.
    step(1'b1, 1'b0);
    for (int e = 1; e <= 45; e++) begin
      step(1'b0, e >= 10);
      if (e == 19) chk("held_req_ack_early", 32'(ack), 32'(0));
      if (e == 19) chk("held_req_dom_early", 32'(dom_rst), 32'(4'h8));
      if (e == 20) chk("held_req_ack_run", 32'(ack), 32'(SW));
      if (e == 21) chk("held_req_dom_accept", 32'(dom_rst), SW ? 32'(4'hF) : 32'(4'h0));
      if (e == 21) chk("held_req_ack_accept", 32'(ack), 32'(0));
      if (e == 41) chk("held_req_done_dom", 32'(dom_rst), 32'(4'h0));
      if (e == 41) chk("held_req_done_ack", 32'(ack), 32'(SW));
    end

    // rst pulse mid-RELEASE restarts the whole sequence.
    step(1'b1, 1'b0);
    for (int e = 1; e <= 13; e++) step(1'b0, 1'b0);
    chk("mid_rst_before", 32'(dom_rst), 32'(4'hC));
    step(1'b1, 1'b0);
    chk("mid_rst_dom", 32'(dom_rst), 32'(4'hF));
    chk("mid_rst_busy", 32'(busy), 32'(1));
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b0);
      if (e == 19) chk("mid_rst_last_pending", 32'(dom_rst), 32'(4'h8));
      if (e == 20) chk("mid_rst_done_dom", 32'(dom_rst), 32'(4'h0));
      if (e == 20) chk("mid_rst_done_busy", 32'(busy), 32'(0));
    end

    // rst and req together in RUN: reset wins, ack stays low for the whole sequence.
    step(1'b1, 1'b1);
    chk("rst_req_dom", 32'(dom_rst), 32'(4'hF));
    chk("rst_req_ack", 32'(ack), 32'(0));
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 1'b0);
      if (e == 19) chk("rst_req_ack_low", 32'(ack), 32'(0));
      if (e == 20) chk("rst_req_ack_done", 32'(ack), 32'(SW));
    end

    // Random phase with occasional resets and bursty, sometimes held, requests.
    begin
      logic q;
      q = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 3) == 0) q = ~q;
        step($urandom_range(0, 59) == 0, q);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adam_rst_seq.md
ADAM_RST_SEQ -- requirements
Module: adam_rst_seq

Interface
REQ-001 Parameter NO_DOMAINS, default 4: number of downstream reset domains; legal range 1..32.
REQ-002 Parameter HOLD, default 8: cycles all domains stay in reset before the first release; legal ≥1.
REQ-003 Parameter DELAY, default 4: cycles between successive domain releases; legal ≥1.
REQ-004 clk  input  1  sole clock, typically the divided clock from adam_clk_div (mst side of its ADAM_SEQ).
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk only.
REQ-006 req  input  1  software re-sequence request, valid-ready style with ack.
REQ-007 ack  output 1  request accept / sequencer idle (RUN); a transfer occurs on an edge with req=1 and ack=1.
REQ-008 busy output 1  high whenever the state is not RUN; equals ~ack when ADAM_RST_SEQ_SW_REQ_EN is defined.
REQ-009 dom_rst output NO_DOMAINS  active-high reset per domain; bit 0 is released first.
REQ-010 All outputs SHALL be registered; no combinational input-to-output paths.

Function
REQ-011 FSM states: ASSERT (all dom_rst=1, counting HOLD), RELEASE (releasing domains in index order, counting DELAY), RUN (all dom_rst=0, idle).
REQ-012 Counter width SHALL be $clog2(max(HOLD,DELAY)+1); domain index width $clog2(NO_DOMAINS)+1; neither SHALL wrap during a sequence.
REQ-013 Numbering rising edges after rst falls as 1,2,...: dom_rst[i] SHALL read 0 after edge HOLD + i*DELAY and remain 0 until the next reset or request.
REQ-014 RUN SHALL be entered, with ack=1 and busy=0, on the same edge that releases dom_rst[NO_DOMAINS-1].
REQ-015 ASSERT→RELEASE on the edge where the hold count reaches HOLD; RELEASE→RUN after the last domain release; RUN→ASSERT on request acceptance.
REQ-016 On an accepted request at edge E: after E, all dom_rst=1, ack=0, busy=1, counter=0; dom_rst[i] SHALL release after edge E+HOLD+i*DELAY.
REQ-017 req while ack=0 SHALL be ignored, not queued; req held high across RUN re-entry SHALL be accepted again on the first edge with ack=1.
REQ-018 Once released, a domain SHALL NOT re-assert except through rst or an accepted request; releases are strictly monotonic in index.
REQ-019 NO_DOMAINS=1: RUN is entered after edge HOLD.

Reset
REQ-020 While rst=1 at an edge: state=ASSERT, counter=0, index=0, dom_rst=all 1s, ack=0, busy=1.
REQ-021 rst=1 mid-RELEASE or in RUN SHALL re-assert all dom_rst after that edge; rst SHALL take priority over a simultaneous req.

Configuration
REQ-022 Macro ADAM_RST_SEQ_SW_REQ_EN defined: req/ack behave per REQ-006/007/016/017.
REQ-023 Macro undefined: req SHALL be ignored and ack SHALL be held 0; the sequence runs only after rst; busy and dom_rst behave unchanged.

Verification (defaults NO_DOMAINS=4, HOLD=8, DELAY=4, SW_REQ_EN defined, clk 5 ns)
REQ-024 rst high 1 cycle, then low -> dom_rst 4'hF to edge 7; 4'hE after 8; 4'hC after 12; 4'h8 after 16; 4'h0 with ack=1, busy=0 after 20.
REQ-025 In RUN, pulse req for 1 cycle at edge E -> dom_rst=4'hF and ack=0 after E; releases after E+8, E+12, E+16, E+20.
REQ-026 req held high from edge 10 (mid-RELEASE) -> no effect before edge 20; accepted at edge 21; new sequence completes at edge 41.
REQ-027 rst asserted for 1 cycle at edge 14 (dom_rst=4'hC) -> 4'hF after 14; full sequence restarts and completes 20 edges after rst falls.
REQ-028 rst=1 and req=1 at the same edge in RUN -> reset behaviour only; ack stays 0 until the sequence completes.
REQ-029 Macro undefined, req tied high -> ack stays 0 throughout; sequence runs once after rst; dom_rst stays 4'h0 in RUN.
